// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the synchronous byte FIFO.
//   FIFO_DATA_WIDTH : default word width in bits
//   FIFO_DEPTH      : default number of entries (power of two)
//   FIFO_ADDR_WIDTH : default pointer width, log2(FIFO_DEPTH)
//   fifo_data_t     : one stored word
//   fifo_ptr_t      : one read/write pointer
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_ADDR_WIDTH = 4;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;
  typedef logic [FIFO_ADDR_WIDTH-1:0] fifo_ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port register array for the FIFO: one synchronous write port
// and one synchronous read port whose registered output is the FIFO read data.
// The array itself is never reset; only the read-data register is.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, clears the read-data register
//   we_i    : write strobe (already qualified by the caller)
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read strobe (already qualified by the caller)
//   raddr_i : read address
//   rdata_o : registered read data, holds when re_i is low
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Storage: written only on an accepted write, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data only moves on an accepted read; otherwise the last word is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Read-data register: reset wins over a read in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : fifo_mem

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Synchronous single-clock FIFO (default 16 x 8) with registered read data and
// combinational full/empty status derived from the occupancy count. Writes to
// a full FIFO and reads from an empty FIFO are dropped without side effects.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   When defined, adds sticky 'overflow' / 'underflow' outputs that record a
//   dropped write / dropped read respectively; both clear only on reset.
//
// Ports:
//   d         : write data
//   we        : write enable
//   re        : read enable
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset (priority over we/re)
//   empty     : FIFO holds 0 entries
//   full      : FIFO holds DEPTH entries
//   out       : registered read data, updated on the edge a read is accepted
//   overflow  : (FIFO_ERR_FLAGS_EN only) sticky dropped-write flag
//   underflow : (FIFO_ERR_FLAGS_EN only) sticky dropped-read flag
// -----------------------------------------------------------------------------
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clk,
  input  logic                  rst,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] out
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  // Count needs one extra bit so that "DEPTH entries" is distinguishable
  // from "0 entries" while the pointers themselves alias.
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic wr_ok;
  logic rd_ok;

  // Status comes straight from the registered count.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Both accept decisions look at the pre-edge status, so a full FIFO with
  // we=re=1 only reads and an empty FIFO with we=re=1 only writes.
  assign wr_ok = we && !full;
  assign rd_ok = re && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Pointers wrap through natural ADDR_WIDTH overflow.
    if (wr_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // The memory sees reset-qualified strobes so nothing is stored or read
  // on a reset edge; read data itself is cleared inside the memory.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_ok && !rst),
    .waddr_i (wptr_q),
    .wdata_i (d),
    .re_i    (rd_ok && !rst),
    .raddr_i (rptr_q),
    .rdata_o (out)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky: once a dropped access is seen the flag stays up until reset.
  always_comb begin
    overflow_d  = overflow_q  || (we && full);
    underflow_d = underflow_q || (re && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : fifo

// File: tb/tb_fifo.sv
module tb_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  fifo_data_t d   = '0;
  logic       empty, full;
  fifo_data_t dout;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  fifo dut (
    .d     (d),
    .we    (we),
    .re    (re),
    .clk   (clk),
    .rst   (rst),
    .empty (empty),
    .full  (full),
    .out   (dout)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    fifo_data_t dout;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } rec_t;

  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference: an ordered queue of stored words plus the last read value.
  fifo_data_t mq[$];
  fifo_data_t mout = '0;
  logic       movf = 1'b0;
  logic       munf = 1'b0;

  // One clock of stimulus; the expected post-edge state is queued for the monitor.
  task automatic step(input logic w, input logic r, input fifo_data_t data, input logic rs);
    int   sz;
    logic do_wr, do_rd;
    rec_t e;
    @(negedge clk);
    we = w; re = r; d = data; rst = rs;
    @(posedge clk);
    sz = mq.size();
    if (rs) begin
      mq.delete();
      mout = '0;
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      do_wr = w && (sz < 16);
      do_rd = r && (sz > 0);
      if (w && sz == 16) movf = 1'b1;
      if (r && sz == 0)  munf = 1'b1;
      if (do_rd) mout = mq.pop_front();
      if (do_wr) mq.push_back(data);
    end
    e.dout  = mout;
    e.empty = (mq.size() == 0);
    e.full  = (mq.size() == 16);
    e.ovf   = movf;
    e.unf   = munf;
    exp_q.push_back(e);
  endtask

  // Monitor: checks the DUT on the falling edge after each stimulus edge.
  always @(negedge clk) begin
    rec_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (dout !== e.dout) begin
        n_bad++;
        $display("FAIL out: got %02h want %02h at %0t", dout, e.dout, $time);
      end
      n_vec++;
      if (empty !== e.empty) begin
        n_bad++;
        $display("FAIL empty: got %b want %b at %0t", empty, e.empty, $time);
      end
      n_vec++;
      if (full !== e.full) begin
        n_bad++;
        $display("FAIL full: got %b want %b at %0t", full, e.full, $time);
      end
`ifdef FIFO_ERR_FLAGS_EN
      n_vec++;
      if (overflow !== e.ovf) begin
        n_bad++;
        $display("FAIL overflow: got %b want %b at %0t", overflow, e.ovf, $time);
      end
      n_vec++;
      if (underflow !== e.unf) begin
        n_bad++;
        $display("FAIL underflow: got %b want %b at %0t", underflow, e.unf, $time);
      end
`endif
    end
  end

  initial begin
    fifo_data_t fill_v [16];
    fill_v = '{8'd3, 8'd7, 8'd1, 8'd0, 8'd5, 8'd2, 8'd6, 8'd4,
               8'd3, 8'd3, 8'd1, 8'd7, 8'd0, 8'd2, 8'd5, 8'd6};

    // Reset with random enables.
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);

    // Fill, then a dropped 17th write.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, fill_v[i], 1'b0);
    step(1'b1, 1'b0, 8'd4, 1'b0);

    // Drain in order, then a dropped 17th read (out stays 6).
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Wrap: pointers cross 15 -> 0 without full ever asserting.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Simultaneous read/write at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Full with we=re=1: read only, then drain the remaining 15.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Empty with we=re=1: write only, out unchanged; then read it back.
    step(1'b1, 1'b1, 8'h77, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Mid-operation reset with 9 entries.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule : tb_fifo
